group_result_drain: RTL

- Sits downstream of the MAC group and drains its accumulated results.
- On a capture strobe, snapshots the full GROUP_NB x RESULT_WIDTH result bus.
- Rescales each lane by an arithmetic right shift and saturates it to OUT_WIDTH.
- Serialises the lanes one per beat, lane 0 first, on a valid/ready stream toward the output buffer.

---
 rtl/group_result_drain.sv | 109 ++++++++++
 1 files changed

// File: rtl/group_result_drain.sv
// Drains a captured MAC-group result bus as a valid/ready stream, one lane per beat.
// Each lane is arithmetically right-shifted by SHIFT and saturated to OUT_WIDTH.
module group_result_drain #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 16,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  localparam int RESULT_WIDTH = IMG_WIDTH + KER_WIDTH + 1,
  localparam int IDX_WIDTH    = (GROUP_NB > 1) ? $clog2(GROUP_NB) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [GROUP_NB*RESULT_WIDTH-1:0] result,
  input  logic                             cap,
  output logic                             busy,
  output logic                             drop,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic [IDX_WIDTH-1:0]             out_idx,
  output logic                             out_last,
  output logic                             out_valid,
  input  logic                             out_ready
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(GROUP_NB - 1);
  localparam logic signed [RESULT_WIDTH-1:0] SAT_MAX =
    {{(RESULT_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RESULT_WIDTH-1:0] SAT_MIN =
    {{(RESULT_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  state_t                            state, state_n;
  logic [GROUP_NB*RESULT_WIDTH-1:0]  snap;
  logic [IDX_WIDTH-1:0]              idx_n, idx_inc;
  logic [OUT_WIDTH-1:0]              data_n;
  logic                              drop_n, load, beat;

  function automatic logic [OUT_WIDTH-1:0] saturate(input logic [RESULT_WIDTH-1:0] lane);
    logic signed [RESULT_WIDTH-1:0] s;
    s = $signed(lane) >>> SHIFT;
    if (s > SAT_MAX)      saturate = SAT_MAX[OUT_WIDTH-1:0];
    else if (s < SAT_MIN) saturate = SAT_MIN[OUT_WIDTH-1:0];
    else                  saturate = s[OUT_WIDTH-1:0];
  endfunction

  assign beat    = (state == SEND) && out_ready;
  assign idx_inc = out_idx + 1'b1;

  // Lane 0 is taken straight from the bus at capture so it is ready one cycle later;
  // later lanes come from the snapshot.
  always_comb begin
    state_n = state;
    idx_n   = out_idx;
    data_n  = out_data;
    drop_n  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (cap) begin
          load    = 1'b1;
          state_n = SEND;
          idx_n   = '0;
          data_n  = saturate(result[0 +: RESULT_WIDTH]);
        end
      end
      SEND: begin
        if (beat && out_idx == LAST_IDX) begin
          idx_n = '0;
          if (cap) begin
            load   = 1'b1;
            data_n = saturate(result[0 +: RESULT_WIDTH]);
          end else begin
            state_n = IDLE;
            data_n  = '0;
          end
        end else begin
          drop_n = cap;
          if (beat) begin
            idx_n  = idx_inc;
            data_n = saturate(snap[idx_inc*RESULT_WIDTH +: RESULT_WIDTH]);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_idx  <= '0;
      out_data <= '0;
      drop     <= 1'b0;
      snap     <= '0;
    end else begin
      state    <= state_n;
      out_idx  <= idx_n;
      out_data <= data_n;
      drop     <= drop_n;
      if (load) snap <= result;
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_last  = out_valid && (out_idx == LAST_IDX);

endmodule
